// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice with a registered carry, fed LSB-first
// from operand shift registers, behind valid/ready handshakes on both sides.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [1:0]         w_fa;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

    // Returns {carry, sum} of a 1-bit full adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    always_comb begin
        w_fa       = full_add(r_a_sh[0], r_b_sh[0], r_carry);
        w_s        = w_fa[0];
        w_c        = w_fa[1];
        // Shift right with the new sum bit entering at the MSB; after WIDTH
        // shifts the accumulator holds the full sum in natural bit order.
        w_acc_next = r_acc >> 1;
        w_acc_next[WIDTH-1] = w_s;
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_state_next = S_ADD;
            S_ADD:  if (w_last)    w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default:               w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_ADD: begin
                    r_acc   <= w_acc_next;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // The result registers only move when the last bit lands.
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
